// File: rtl/frame_tx.sv
// UART response framer: sends 0x55, cmd, len and up to four payload bytes
// as 8N1 characters, with CLK_DIV clock cycles per bit.
module frame_tx #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [7:0]  req_len,
  input  logic [31:0] req_data,
  output logic        ser_out,
  output logic        busy,
  output logic        frame_done,
  output logic        len_err
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned LEN_W = 3;
  localparam logic [7:0]  SYNC_BYTE = 8'h55;
  localparam logic [7:0]  MAX_LEN   = 8'd4;
  localparam logic [BIT_W-1:0] STOP_BIT = BIT_W'(9);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] CMD  = 3'd2;
  localparam logic [2:0] LEN  = 3'd3;
  localparam logic [2:0] DATA = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [8:0]       shift, shift_nxt;
  logic [7:0]       cmd_q, cmd_q_nxt;
  logic [LEN_W-1:0] len_q, len_q_nxt;
  logic [LEN_W-1:0] data_left, data_left_nxt;
  logic [31:0]      data_q, data_q_nxt;
  logic             ser_out_nxt, req_ready_nxt, busy_nxt;
  logic             frame_done_nxt, len_err_nxt;
  logic             bit_end, byte_end, load;
  logic [7:0]       load_byte;

  // State and datapath registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '1;
      cmd_q      <= '0;
      len_q      <= '0;
      data_left  <= '0;
      data_q     <= '0;
      ser_out    <= 1'b1;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      cmd_q      <= cmd_q_nxt;
      len_q      <= len_q_nxt;
      data_left  <= data_left_nxt;
      data_q     <= data_q_nxt;
      ser_out    <= ser_out_nxt;
      req_ready  <= req_ready_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      len_err    <= len_err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    div_cnt_nxt   = div_cnt;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    cmd_q_nxt     = cmd_q;
    len_q_nxt     = len_q;
    data_left_nxt = data_left;
    data_q_nxt    = data_q;
    ser_out_nxt   = ser_out;
    len_err_nxt   = 1'b0;
    load          = 1'b0;
    load_byte     = 8'h00;
    bit_end       = (div_cnt == DIV_LAST);
    byte_end      = bit_end && (bit_cnt == STOP_BIT);

    case (state)
      IDLE: begin
        ser_out_nxt = 1'b1;
        div_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (req_valid && req_ready) begin
          state_nxt   = HDR;
          cmd_q_nxt   = req_cmd;
          len_q_nxt   = (req_len > MAX_LEN) ? LEN_W'(MAX_LEN) : req_len[LEN_W-1:0];
          data_q_nxt  = req_data;
          len_err_nxt = (req_len > MAX_LEN);
          load        = 1'b1;
          load_byte   = SYNC_BYTE;
        end
      end
      HDR, CMD, LEN, DATA: begin
        div_cnt_nxt = bit_end ? '0 : div_cnt + DIV_W'(1);
        if (bit_end && !byte_end) begin
          ser_out_nxt = shift[0];
          shift_nxt   = {1'b1, shift[8:1]};
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
        if (byte_end) begin
          ser_out_nxt = 1'b1;
          case (state)
            HDR: begin
              state_nxt = CMD;
              load      = 1'b1;
              load_byte = cmd_q;
            end
            CMD: begin
              state_nxt = LEN;
              load      = 1'b1;
              load_byte = 8'(len_q);
            end
            LEN: begin
              if (len_q != '0) begin
                state_nxt     = DATA;
                load          = 1'b1;
                load_byte     = data_q[7:0];
                data_q_nxt    = {8'h00, data_q[31:8]};
                data_left_nxt = len_q - LEN_W'(1);
              end else begin
                state_nxt = DONE;
              end
            end
            default: begin
              if (data_left != '0) begin
                load          = 1'b1;
                load_byte     = data_q[7:0];
                data_q_nxt    = {8'h00, data_q[31:8]};
                data_left_nxt = data_left - LEN_W'(1);
              end else begin
                state_nxt = DONE;
              end
            end
          endcase
        end
      end
      DONE: begin
        ser_out_nxt = 1'b1;
        div_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        state_nxt   = IDLE;
      end
      default: begin
        ser_out_nxt = 1'b1;
        state_nxt   = IDLE;
      end
    endcase

    // A new character starts with its start bit; the stop bit is preloaded in shift[8].
    if (load) begin
      ser_out_nxt = 1'b0;
      shift_nxt   = {1'b1, load_byte};
      bit_cnt_nxt = '0;
      div_cnt_nxt = '0;
    end

    frame_done_nxt = (state_nxt == DONE);
    req_ready_nxt  = (state_nxt == IDLE);
    busy_nxt       = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_frame_tx.sv
// Bench for frame_tx: directed and random frames checked against a
// byte-level UART line model.
module tb_frame_tx;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [7:0]  req_len;
  logic [31:0] req_data;
  logic        ser_out;
  logic        busy;
  logic        frame_done;
  logic        len_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frame_tx #(.CLK_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_len    (req_len),
    .req_data   (req_data),
    .ser_out    (ser_out),
    .busy       (busy),
    .frame_done (frame_done),
    .len_err    (len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and return one step past the accepting edge (first start-bit cycle).
  task automatic request(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] data);
    bit ok;
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_len   = len;
    req_data  = data;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (req_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    chk("accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Check one whole frame starting at cycle accept+1; returns at cycle accept+N+3.
  task automatic observe(input string name, input logic [7:0] cmd, input logic [7:0] len,
                         input logic [31:0] data, input bit hold, input logic [31:0] new_data);
    logic [7:0] exp_q[$];
    logic [7:0] rx[$];
    logic       line[];
    int         eff, n, errs, stat_errs, lerr, fd_early, idx, pos;
    logic       bit_exp;
    logic [7:0] v;
    logic [31:0] nonce;

    eff = (len > 8'd4) ? 4 : int'(len);
    exp_q.push_back(8'h55);
    exp_q.push_back(cmd);
    exp_q.push_back(8'(eff));
    for (int i = 0; i < eff; i++) exp_q.push_back(data[8*i +: 8]);
    n = 10 * exp_q.size() * D;
    line = new[n];
    errs = 0; stat_errs = 0; lerr = 0; fd_early = 0;

    if (hold) begin
      req_data = new_data;
    end else begin
      req_valid = 1'b0;
      req_cmd   = ~cmd;
      req_len   = 8'hff;
      req_data  = $urandom;
    end

    chk({name, "_len_err_first"}, 64'(len_err), 64'(len > 8'd4));
    for (int k = 1; k <= n; k++) begin
      idx = (k - 1) / (10 * D);
      pos = ((k - 1) / D) % 10;
      bit_exp = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : exp_q[idx][pos-1];
      line[k-1] = ser_out;
      if (ser_out !== bit_exp) errs++;
      if (frame_done !== 1'b0) fd_early++;
      if (len_err === 1'b1) lerr++;
      if (busy !== 1'b1 || req_ready !== 1'b0) stat_errs++;
      @(posedge clk);
      #1;
    end
    chk({name, "_done_pulse"}, 64'(frame_done), 64'd1);
    chk({name, "_done_line"}, 64'(ser_out), 64'd1);
    @(posedge clk);
    #1;
    chk({name, "_done_clear"}, 64'(frame_done), 64'd0);
    chk({name, "_ready_after"}, {63'd0, req_ready}, 64'd1);
    chk({name, "_bitstream_errs"}, 64'(errs), 64'd0);
    chk({name, "_status_errs"}, 64'(stat_errs), 64'd0);
    chk({name, "_early_done"}, 64'(fd_early), 64'd0);
    chk({name, "_len_err_count"}, 64'(lerr), 64'(len > 8'd4));

    // Mid-bit sampling receiver.
    for (int b = 0; b < exp_q.size(); b++) begin
      for (int j = 0; j < 8; j++) v[j] = line[(b * 10 + 1 + j) * D + D / 2];
      rx.push_back(v);
      chk($sformatf("%s_byte%0d", name, b), 64'(v), 64'(exp_q[b]));
    end
    if (eff == 4) begin
      nonce = 32'h0;
      for (int i = 0; i < 4; i++) nonce = {rx[3 + i], nonce[31:8]};
      chk({name, "_nonce"}, 64'(nonce), 64'(data));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string name, input int cycles);
    int e;
    e = 0;
    for (int i = 0; i < cycles; i++) begin
      if (ser_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || req_ready !== 1'b1) e++;
      @(posedge clk);
      #1;
    end
    chk({name, "_idle_errs"}, 64'(e), 64'd0);
  endtask

  initial begin
    logic [7:0]  rc, rl;
    logic [31:0] rd;

    rst       = 1'b1;
    req_valid = 1'b1;
    req_cmd   = 8'h01;
    req_len   = 8'h01;
    req_data  = 32'h0000_005a;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ser_out", 64'(ser_out), 64'd1);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle_check("post_rst", 20);

    request(8'h01, 8'd1, 32'h0000_005a);
    observe("loop_ack", 8'h01, 8'd1, 32'h0000_005a, 1'b0, 32'h0);

    request(8'h00, 8'd4, 32'h1234_5678);
    observe("nonce", 8'h00, 8'd4, 32'h1234_5678, 1'b0, 32'h0);

    request(8'h01, 8'd0, 32'hdead_beef);
    observe("zero_len", 8'h01, 8'd0, 32'hdead_beef, 1'b0, 32'h0);

    request(8'h01, 8'd7, 32'haabb_ccdd);
    observe("oversize", 8'h01, 8'd7, 32'haabb_ccdd, 1'b0, 32'h0);

    // Reset inside bit 15 of a frame.
    request(8'h00, 8'd2, 32'h0000_c3a5);
    req_valid = 1'b0;
    repeat (15 * D + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ser_out", 64'(ser_out), 64'd1);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    idle_check("midrst", 200);
    request(8'h00, 8'd2, 32'h0000_9966);
    observe("after_rst", 8'h00, 8'd2, 32'h0000_9966, 1'b0, 32'h0);

    // Held request: second frame follows DONE with the later data.
    request(8'h01, 8'd1, 32'h0000_0011);
    observe("held1", 8'h01, 8'd1, 32'h0000_0011, 1'b1, 32'h0000_0022);
    observe("held2", 8'h01, 8'd1, 32'h0000_0022, 1'b0, 32'h0);
    idle_check("held_end", 300);

    for (int t = 0; t < 6; t++) begin
      rc = 8'($urandom);
      rl = 8'($urandom_range(0, 7));
      rd = $urandom;
      request(rc, rl, rd);
      observe($sformatf("rand%0d", t), rc, rl, rd, 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_tx.md
FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 Parameter CLK_DIV, default 868, SHALL set the clock cycles per UART bit (100 MHz / 115200); legal values are 2 and above.
REQ-002 Ports SHALL be, one per line, as follows:
  clk  input  1  single clock, rising edge.
  rst  input  1  synchronous, active-high reset.
  req_valid  input  1  a response frame is requested.
  req_ready  output  1  framer is idle and accepts a request.
  req_cmd  input  8  command byte of the response (0x00 nonce, 0x01 loop ack).
  req_len  input  8  payload byte count, legal 0..4.
  req_data  input  32  payload, sent least-significant byte first.
  ser_out  output  1  UART serial line, idle high.
  busy  output  1  a frame is in progress.
  frame_done  output  1  one-cycle pulse after the last stop bit.
  len_err  output  1  one-cycle pulse when req_len > 4 is accepted.

Function
REQ-003 A request SHALL be accepted in the cycle where req_valid && req_ready; req_cmd, req_len and req_data SHALL be captured in that cycle, and later input changes SHALL have no effect on the frame.
REQ-004 The frame SHALL be the byte sequence 0x55, cmd, len, then len payload bytes taken from req_data[7:0], [15:8], [23:16], [31:24] in that order.
REQ-005 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with no parity.
REQ-006 Every bit SHALL last exactly CLK_DIV cycles, using a divider counter that runs 0..CLK_DIV-1 and wraps to 0.
REQ-007 Bytes within a frame SHALL be sent back-to-back with no idle gap between them; a frame SHALL occupy 10*(3+len) bit times.
REQ-008 The start bit of 0x55 SHALL appear on ser_out in the cycle after acceptance.
REQ-009 The state machine SHALL have the states IDLE, HDR, CMD, LEN, DATA and DONE.
REQ-010 State transitions SHALL be as follows:
  IDLE->HDR on acceptance.
  HDR->CMD->LEN at each byte's stop-bit end.
  LEN->DATA if len>0, otherwise LEN->DONE.
  DATA->DONE after the last payload byte.
  DONE->IDLE after 1 cycle.
REQ-011 req_ready SHALL be 1 only in IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 frame_done SHALL be 1 only in DONE, i.e. for exactly one cycle, starting the cycle after the final stop bit's last cycle.
REQ-014 A back-to-back request SHALL be accepted no earlier than the cycle after DONE.
REQ-015 If req_len > 4, the len byte sent SHALL be 0x04, exactly 4 payload bytes SHALL be sent, and len_err SHALL pulse in the cycle after acceptance.
REQ-016 For req_len = 0, the frame SHALL be 0x55, cmd, 0x00 only, and no DATA state SHALL be entered.
REQ-017 ser_out SHALL be 1 in IDLE and DONE.
REQ-018 A req_valid held high while busy SHALL be ignored until IDLE and then accepted with the input values present at that time.
REQ-019 The outputs SHALL be registered, with no combinational path from req_* to ser_out.

Reset
REQ-020 While rst=1 at a clock edge, the block SHALL enter IDLE and set ser_out=1, req_ready=1, busy=0, frame_done=0 and len_err=0, with the divider and bit counters cleared.
REQ-021 A reset mid-frame SHALL abandon the frame: ser_out SHALL go high the next cycle, no frame_done SHALL pulse, and the captured request SHALL be discarded.
REQ-022 A request presented while rst=1 SHALL NOT be accepted.

Verification (CLK_DIV=4)
REQ-023 Loop ack: cmd 0x01, len 1, data 0x0000005A.
  Required line bytes: 55 01 01 5A, 40 bits = 160 cycles.
  Required timing: frame_done in cycle accept+161.
REQ-024 Nonce: cmd 0x00, len 4, data 0x12345678.
  Required line bytes: 55 00 04 78 56 34 12.
  A receiver shifting {byte, nonce[31:8]} SHALL reconstruct 0x12345678.
REQ-025 Zero length: cmd 0x01, len 0.
  Required line bytes: 55 01 00, 120 cycles.
  The DATA state SHALL never be entered.
REQ-026 Oversize length: len 7, data 0xAABBCCDD.
  Required line bytes: 55 cmd 04 DD CC BB AA.
  len_err SHALL pulse exactly once, in cycle accept+1.
REQ-027 Reset mid-frame: assert rst during bit 15.
  Required response: ser_out=1 and req_ready=1 the next cycle, and frame_done never pulses.
  A following request SHALL produce a complete, correct frame.
REQ-028 Held request: req_valid stays high and data changes from 0x11 to 0x22 during the first frame.
  The first frame SHALL carry 0x11.
  A second frame carrying 0x22 SHALL start in the cycle after DONE+1, and exactly two frames SHALL be sent.
